// File: rtl/pmalu_seq.sv
// pmalu_seq: sequencer and 4x4 register file front end for the 4-bit ALU.
// Optional zero flag output enabled by defining PMALU_SEQ_ZFLAG_EN.
module pmalu_seq #(
    parameter int NREG = 4,
    parameter int DW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [14:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic [2:0]    alu_s,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_cin,
    input  logic [DW-1:0] alu_y,
    output logic          done,
    output logic [DW-1:0] result,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
`ifdef PMALU_SEQ_ZFLAG_EN
    ,
    output logic          zflag
`endif
);

    typedef enum logic {
        IDLE,
        EXEC
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   rf_q [NREG];
    logic [DW-1:0]   rf_d [NREG];
    logic [1:0]      rd_q, rd_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [2:0]      s_q, s_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic            cin_q, cin_d;
    logic            done_q, done_d;
    logic [DW-1:0]   res_q, res_d;
    logic            z_q, z_d;

    // Instruction fields
    logic [2:0]      f_op;
    logic [1:0]      f_rd;
    logic [1:0]      f_rs;
    logic            f_ui;
    logic [DW-1:0]   f_imm;
    logic            f_cin;
    logic [1:0]      f_rep;

    assign f_op  = instr[14:12];
    assign f_rd  = instr[11:10];
    assign f_rs  = instr[9:8];
    assign f_ui  = instr[7];
    assign f_imm = instr[6:3];
    assign f_cin = instr[2];
    assign f_rep = instr[1:0];

    assign instr_ready = (state_q == IDLE);
    assign alu_s       = s_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_cin     = cin_q;
    assign done        = done_q;
    assign result      = res_q;
    assign dbg_data    = rf_q[dbg_sel];

`ifdef PMALU_SEQ_ZFLAG_EN
    assign zflag = z_q;
`endif

    // Next-state: accept in IDLE, write back and iterate in EXEC
    always_comb begin
        state_d = state_q;
        rf_d    = rf_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        done_d  = 1'b0;
        res_d   = res_q;
        z_d     = z_q;
        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    rd_d    = f_rd;
                    cnt_d   = f_rep;
                    s_d     = f_op;
                    a_d     = rf_q[f_rd];
                    b_d     = f_ui ? f_imm : rf_q[f_rs];
                    cin_d   = f_cin;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rf_d[rd_q] = alu_y;
                if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                    a_d   = alu_y;
                end else begin
                    res_d   = alu_y;
                    z_d     = (alu_y == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register file, all cleared by async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            rf_q    <= rf_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            done_q  <= done_d;
            res_q   <= res_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_pmalu_seq.sv
// tb_pmalu_seq: directed and random checks of pmalu_seq against a
// register-file model, with a behavioural ALU on the return path.
module tb_pmalu_seq;

    logic        clk;
    logic        rst_n;
    logic [14:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  alu_s;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_cin;
    logic [3:0]  alu_y;
    logic        done;
    logic [3:0]  result;
    logic [1:0]  dbg_sel;
    logic [3:0]  dbg_data;
`ifdef PMALU_SEQ_ZFLAG_EN
    logic        zflag;
`endif

    int total;
    int passed;
    logic [3:0] rf_m [4];

    pmalu_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .alu_s(alu_s),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_cin(alu_cin),
        .alu_y(alu_y),
        .done(done),
        .result(result),
        .dbg_sel(dbg_sel),
        .dbg_data(dbg_data)
`ifdef PMALU_SEQ_ZFLAG_EN
        ,
        .zflag(zflag)
`endif
    );

    // Behavioural 4-bit ALU
    function automatic logic [3:0] alu_f(input logic [2:0] s,
                                         input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic c);
        case (s)
            3'd0:    return a + b + {3'b000, c};
            3'd1:    return a + ~b + {3'b000, c};
            3'd2:    return b;
            3'd3:    return a;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return ~a;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_y = alu_f(alu_s, alu_a, alu_b, alu_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check(tag, 8'(dbg_data), 8'(rf_m[i]));
        end
    endtask

    // Issue one instruction; optionally poke a one-cycle valid while busy
    task automatic run(input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic ui,
                       input logic [3:0] imm, input logic cin,
                       input logic [1:0] rep, input bit poke);
        logic [3:0] a;
        logic [3:0] b;
        int n;
        n = 0;
        while (!instr_ready && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_wait", 8'(instr_ready), 8'd1);
        a = rf_m[rd];
        b = ui ? imm : rf_m[rs];
        instr = {op, rd, rs, ui, imm, cin, rep};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 15'($urandom);
        for (int i = 0; i <= int'(rep); i++) begin
            check("exec_a", 8'(alu_a), 8'(a));
            check("exec_b", 8'(alu_b), 8'(b));
            check("exec_s", 8'(alu_s), 8'(op));
            check("exec_busy", 8'(instr_ready), 8'd0);
            check("exec_nodone", 8'(done), 8'd0);
            if (poke && i == 0) begin
                instr = {3'd2, rd ^ 2'd1, 2'd0, 1'b1, 4'hf, 1'b0, 2'd0};
                instr_valid = 1'b1;
            end
            a = alu_f(op, a, b, cin);
            @(posedge clk);
            #1;
            instr_valid = 1'b0;
        end
        rf_m[rd] = a;
        check("done", 8'(done), 8'd1);
        check("result", 8'(result), 8'(a));
`ifdef PMALU_SEQ_ZFLAG_EN
        check("zflag", 8'(zflag), 8'(a == 4'd0));
`endif
        check_rf("rf");
        @(posedge clk);
        #1;
        check("done_pulse", 8'(done), 8'd0);
        check("result_hold", 8'(result), 8'(a));
    endtask

    initial begin
        total = 0;
        passed = 0;
        for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
        rst_n = 1'b0;
        instr = 15'd0;
        instr_valid = 1'b0;
        dbg_sel = 2'd0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", 8'(instr_ready), 8'd1);
        check("rst_done", 8'(done), 8'd0);
        check("rst_result", 8'(result), 8'd0);
        check("rst_alu_a", 8'(alu_a), 8'd0);
        check("rst_alu_s", 8'(alu_s), 8'd0);
        check_rf("rst_rf");

        // Load immediate and repeated accumulation with wrap
        run(3'd2, 2'd1, 2'd0, 1'b1, 4'd5, 1'b0, 2'd0, 1'b0);
        check("ldi5", 8'(result), 8'd5);
        run(3'd0, 2'd1, 2'd0, 1'b1, 4'd3, 1'b0, 2'd2, 1'b1);
        check("add_rep", 8'(result), 8'd14);
        run(3'd0, 2'd1, 2'd0, 1'b1, 4'd3, 1'b0, 2'd0, 1'b0);
        check("add_wrap", 8'(result), 8'd1);
        run(3'd1, 2'd1, 2'd0, 1'b1, 4'd4, 1'b1, 2'd0, 1'b0);
        check("sub_wrap", 8'(result), 8'd13);
        run(3'd1, 2'd1, 2'd0, 1'b1, 4'd13, 1'b1, 2'd0, 1'b0);
        check("sub_zero", 8'(result), 8'd0);

        // Register operands and logic ops
        run(3'd2, 2'd2, 2'd0, 1'b1, 4'ha, 1'b0, 2'd0, 1'b0);
        run(3'd2, 2'd3, 2'd0, 1'b1, 4'h6, 1'b0, 2'd0, 1'b0);
        run(3'd7, 2'd2, 2'd3, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        check("xor", 8'(result), 8'h0c);
        run(3'd4, 2'd3, 2'd2, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        check("and", 8'(result), 8'h04);
        run(3'd6, 2'd3, 2'd2, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
        check("not", 8'(result), 8'h0b);
        // rd == rs: b stays the pre-instruction value
        run(3'd0, 2'd2, 2'd2, 1'b0, 4'd0, 1'b0, 2'd2, 1'b0);

        // Back-to-back with valid held
        instr = {3'd2, 2'd0, 2'd0, 1'b1, 4'd7, 1'b0, 2'd0};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr = {3'd0, 2'd0, 2'd0, 1'b1, 4'd1, 1'b0, 2'd1};
        check("b2b_busy", 8'(instr_ready), 8'd0);
        @(posedge clk);
        #1;
        check("b2b_done1", 8'(done), 8'd1);
        check("b2b_ready", 8'(instr_ready), 8'd1);
        check("b2b_res1", 8'(result), 8'd7);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("b2b_nogap", 8'(instr_ready), 8'd0);
        check("b2b_a0", 8'(alu_a), 8'd7);
        @(posedge clk);
        #1;
        check("b2b_a1", 8'(alu_a), 8'd8);
        @(posedge clk);
        #1;
        check("b2b_done2", 8'(done), 8'd1);
        check("b2b_res2", 8'(result), 8'd9);
        rf_m[0] = 4'd9;
        check_rf("b2b_rf");

        // Randomized instructions
        for (int k = 0; k < 25; k++) begin
            run(3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                4'($urandom), 1'($urandom), 2'($urandom),
                1'($urandom));
        end

        // Reset in the middle of a rep=3 add
        @(posedge clk);
        #1;
        instr = {3'd0, 2'd1, 2'd0, 1'b1, 4'd1, 1'b0, 2'd3};
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) rf_m[i] = 4'd0;
        check("mid_alu_s", 8'(alu_s), 8'd0);
        check("mid_alu_a", 8'(alu_a), 8'd0);
        check("mid_alu_b", 8'(alu_b), 8'd0);
        check("mid_alu_cin", 8'(alu_cin), 8'd0);
        check("mid_done", 8'(done), 8'd0);
        check("mid_result", 8'(result), 8'd0);
        check_rf("mid_rf");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_nodone", 8'(done), 8'd0);
            check("post_rst_ready", 8'(instr_ready), 8'd1);
        end
        run(3'd2, 2'd3, 2'd0, 1'b1, 4'd9, 1'b0, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
